spi_sram_responder: RTL and testbench

//  SPI mode-0 serial-SRAM target: the device end of the SPI RAM link the SoC master drives on
//  spi_clk_ram/spi_cs_n_ram/spi_mosi_ram/spi_miso_ram. Implements READ (0x03) and WRITE (0x02)

---
 rtl/spi_sram_responder.sv | 238 +++++++++++++++++++++++
 tb/tb_spi_sram_responder.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_sram_responder.sv
// SPI mode-0 serial-SRAM target (READ 0x03 / WRITE 0x02, 24-bit address,
// sequential bursts) backed by an internal byte array. The SPI pins are
// oversampled in the clk domain, so SCK must stay well below clk/8.
module spi_sram_responder #(
    parameter int ADDR_BITS = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic CLK,
    input  logic CS_N,
    input  logic MOSI,
    output logic MISO,
    output logic busy,
    output logic wr_pulse,
    output logic cmd_err
);

    localparam int DEPTH = 1 << ADDR_BITS;

    localparam logic [7:0] OP_READ  = 8'h03;
    localparam logic [7:0] OP_WRITE = 8'h02;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_RDATA,
        S_WDATA,
        S_IGNORE
    } state_t;

    // Synchroniser chains: bit 1 is the usable synced value, bit 2 the
    // previous synced value used for edge detection.
    logic [2:0] sck_q;
    logic [2:0] csn_q;
    logic [1:0] mosi_q;

    logic sck_rise;
    logic sck_fall;
    logic cs_high;
    logic cs_fall;
    logic mosi_s;

    // Frame state
    state_t               state_q;
    logic [4:0]           bit_cnt_q;
    logic [23:0]          sr_q;        // shared rx shifter: opcode, address, write byte
    logic [23:0]          sr_nxt;
    logic [7:0]           tx_q;        // read-data shifter, MSB leaves first
    logic [ADDR_BITS-1:0] addr_q;
    logic [ADDR_BITS-1:0] addr_nxt;
    logic                 is_rd_q;
    logic                 fetch_q;     // next read byte is loaded the cycle after the 8th fall

    // Registered outputs
    logic miso_q;
    logic busy_q;
    logic wr_pulse_q;
    logic cmd_err_q;

    // Array write port, registered so the array itself needs no reset
    logic                 mem_we_q;
    logic [ADDR_BITS-1:0] mem_wa_q;
    logic [7:0]           mem_wd_q;
    logic [7:0]           mem [0:DEPTH-1];

    // The oldest shifter bit falls off the end and is never consumed.
    logic unused_sr_msb;
    assign unused_sr_msb = sr_q[23];

    // Two-flop synchronisers plus one history flop for edge detection;
    // idle levels (SCK low, CS_N high) are restored on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sck_q  <= 3'b000;
            csn_q  <= 3'b111;
            mosi_q <= 2'b00;
        end else begin
            sck_q  <= {sck_q[1:0], CLK};
            csn_q  <= {csn_q[1:0], CS_N};
            mosi_q <= {mosi_q[0], MOSI};
        end
    end

    assign sck_rise = sck_q[1] & ~sck_q[2];
    assign sck_fall = ~sck_q[1] & sck_q[2];
    assign cs_high  = csn_q[1];
    assign cs_fall  = ~csn_q[1] & csn_q[2];
    assign mosi_s   = mosi_q[1];

    assign sr_nxt   = {sr_q[22:0], mosi_s};
    assign addr_nxt = sr_nxt[ADDR_BITS-1:0];   // upper address bits discarded

    // Frame FSM: decodes opcode/address, streams read data on SCK falls and
    // assembles write bytes on SCK rises. CS_N high aborts from any state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            bit_cnt_q  <= '0;
            sr_q       <= '0;
            tx_q       <= '0;
            addr_q     <= '0;
            is_rd_q    <= 1'b0;
            fetch_q    <= 1'b0;
            miso_q     <= 1'b0;
            busy_q     <= 1'b0;
            wr_pulse_q <= 1'b0;
            cmd_err_q  <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_wa_q   <= '0;
            mem_wd_q   <= '0;
        end else begin
            wr_pulse_q <= 1'b0;
            mem_we_q   <= 1'b0;
            fetch_q    <= 1'b0;
            busy_q     <= ~cs_high;

            if (cs_high) begin
                // Deselect: any partial byte is simply dropped.
                state_q   <= S_IDLE;
                bit_cnt_q <= '0;
                miso_q    <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        miso_q <= 1'b0;
                        if (cs_fall) begin
                            state_q   <= S_CMD;
                            bit_cnt_q <= '0;
                        end
                    end

                    S_CMD: begin
                        miso_q <= 1'b0;
                        if (sck_rise) begin
                            sr_q <= sr_nxt;
                            if (bit_cnt_q == 5'd7) begin
                                bit_cnt_q <= '0;
                                case (sr_nxt[7:0])
                                    OP_READ: begin
                                        state_q <= S_ADDR;
                                        is_rd_q <= 1'b1;
                                    end
                                    OP_WRITE: begin
                                        state_q <= S_ADDR;
                                        is_rd_q <= 1'b0;
                                    end
                                    default: begin
                                        state_q   <= S_IGNORE;
                                        cmd_err_q <= 1'b1;
                                    end
                                endcase
                            end else begin
                                bit_cnt_q <= bit_cnt_q + 5'd1;
                            end
                        end
                    end

                    S_ADDR: begin
                        miso_q <= 1'b0;
                        if (sck_rise) begin
                            sr_q <= sr_nxt;
                            if (bit_cnt_q == 5'd23) begin
                                bit_cnt_q <= '0;
                                addr_q    <= addr_nxt;
                                if (is_rd_q) begin
                                    // Preload so the fall after this rise can drive bit 7.
                                    tx_q    <= mem[addr_nxt];
                                    state_q <= S_RDATA;
                                end else begin
                                    state_q <= S_WDATA;
                                end
                            end else begin
                                bit_cnt_q <= bit_cnt_q + 5'd1;
                            end
                        end
                    end

                    S_RDATA: begin
                        if (fetch_q) begin
                            tx_q <= mem[addr_q];
                        end
                        if (sck_fall) begin
                            miso_q <= tx_q[7];
                            tx_q   <= {tx_q[6:0], 1'b0};
                            if (bit_cnt_q == 5'd7) begin
                                bit_cnt_q <= '0;
                                addr_q    <= addr_q + 1'b1;
                                fetch_q   <= 1'b1;
                            end else begin
                                bit_cnt_q <= bit_cnt_q + 5'd1;
                            end
                        end
                    end

                    S_WDATA: begin
                        miso_q <= 1'b0;
                        if (sck_rise) begin
                            sr_q <= sr_nxt;
                            if (bit_cnt_q == 5'd7) begin
                                bit_cnt_q  <= '0;
                                mem_we_q   <= 1'b1;
                                mem_wa_q   <= addr_q;
                                mem_wd_q   <= sr_nxt[7:0];
                                wr_pulse_q <= 1'b1;
                                addr_q     <= addr_q + 1'b1;
                            end else begin
                                bit_cnt_q <= bit_cnt_q + 5'd1;
                            end
                        end
                    end

                    S_IGNORE: begin
                        miso_q <= 1'b0;
                    end

                    default: begin
                        state_q <= S_IDLE;
                        miso_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Byte array write port; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (mem_we_q) begin
            mem[mem_wa_q] <= mem_wd_q;
        end
    end

    assign MISO     = miso_q;
    assign busy     = busy_q;
    assign wr_pulse = wr_pulse_q;
    assign cmd_err  = cmd_err_q;

endmodule

// File: tb/tb_spi_sram_responder.sv
// Bench for spi_sram_responder: acts as SPI master, keeps a byte-array model
// of the SRAM and compares read bursts, strobes and flags against it.
module tb_spi_sram_responder;

    localparam int AB    = 10;
    localparam int DEPTH = 1 << AB;
    localparam int HALF  = 6;   // SCK half-period in clk cycles

    logic clk  = 1'b0;
    logic rst  = 1'b1;
    logic CLK  = 1'b0;
    logic CS_N = 1'b1;
    logic MOSI = 1'b0;
    logic MISO, busy, wr_pulse, cmd_err;

    spi_sram_responder #(.ADDR_BITS(AB)) dut (
        .clk(clk), .rst(rst), .CLK(CLK), .CS_N(CS_N), .MOSI(MOSI),
        .MISO(MISO), .busy(busy), .wr_pulse(wr_pulse), .cmd_err(cmd_err)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;

    // Reference model: bytes the bench has written, plus which are known.
    logic [7:0] ref_mem [DEPTH];
    bit         known   [DEPTH];

    logic [7:0] wq[$];   // bytes to write in the next burst
    logic [7:0] rq[$];   // bytes captured by the last read burst

    int wr_cnt  = 0;
    int miso_hi = 0;
    always @(posedge clk) if (wr_pulse === 1'b1) wr_cnt++;
    always @(negedge clk) if (MISO !== 1'b0) miso_hi++;

    initial begin
        #900us;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1, "watchdog");
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Shift nbits of tx (MSB first); MISO is sampled just before each rise.
    task automatic spi_xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = '0;
        for (int i = 7; i > 7 - nbits; i--) begin
            MOSI = tx[i];
            wait_clk(HALF);
            rx[i] = MISO;
            CLK = 1'b1;
            wait_clk(HALF);
            CLK = 1'b0;
        end
    endtask

    task automatic cs_begin();
        CS_N = 1'b0;
        wait_clk(HALF);
    endtask

    task automatic cs_end();
        wait_clk(HALF);
        CS_N = 1'b1;
        MOSI = 1'b0;
        wait_clk(2 * HALF);
    endtask

    task automatic send_hdr(input logic [7:0] op, input logic [23:0] a);
        logic [7:0] r;
        spi_xfer(op, 8, r);
        spi_xfer(a[23:16], 8, r);
        spi_xfer(a[15:8], 8, r);
        spi_xfer(a[7:0], 8, r);
    endtask

    // Write everything in wq starting at a; model wraps on the low AB bits.
    task automatic write_burst(input logic [23:0] a);
        logic [7:0] r;
        int idx;
        cs_begin();
        send_hdr(8'h02, a);
        for (int i = 0; i < wq.size(); i++) begin
            spi_xfer(wq[i], 8, r);
            idx = (int'(a) + i) % DEPTH;
            ref_mem[idx] = wq[i];
            known[idx]   = 1'b1;
        end
        cs_end();
        wq.delete();
    endtask

    task automatic read_burst(input logic [23:0] a, input int n);
        logic [7:0] r;
        rq.delete();
        cs_begin();
        send_hdr(8'h03, a);
        for (int i = 0; i < n; i++) begin
            spi_xfer(8'h00, 8, r);
            rq.push_back(r);
        end
        cs_end();
    endtask

    task automatic test_reset();
        wait_clk(3);
        rst = 1'b0;
        wait_clk(3);
        vectors++; if (MISO !== 1'b0)     begin errors++; $display("FAIL reset_miso got %b want 0", MISO); end
        vectors++; if (busy !== 1'b0)     begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        vectors++; if (wr_pulse !== 1'b0) begin errors++; $display("FAIL reset_wr_pulse got %b want 0", wr_pulse); end
        vectors++; if (cmd_err !== 1'b0)  begin errors++; $display("FAIL reset_cmd_err got %b want 0", cmd_err); end
    endtask

    // Random fill of 0x3F0..0x03F (wraps through 0) so later reads compare known data.
    task automatic test_prefill();
        int w0;
        w0 = wr_cnt;
        for (int i = 0; i < 80; i++) wq.push_back(8'($urandom));
        write_burst(24'hC003F0);
        vectors++;
        if (wr_cnt - w0 !== 80) begin errors++; $display("FAIL prefill_wr_pulses got %0d want 80", wr_cnt - w0); end
    endtask

    task automatic test_write();
        logic [7:0] r;
        int w0;
        w0 = wr_cnt;
        cs_begin();
        vectors++; if (busy !== 1'b1) begin errors++; $display("FAIL write_busy got %b want 1", busy); end
        send_hdr(8'h02, 24'h000010);
        spi_xfer(8'hA5, 8, r);
        spi_xfer(8'h3C, 8, r);
        cs_end();
        ref_mem[16] = 8'hA5; known[16] = 1'b1;
        ref_mem[17] = 8'h3C; known[17] = 1'b1;
        vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL write_busy_end got %b want 0", busy); end
        vectors++; if (wr_cnt - w0 !== 2) begin errors++; $display("FAIL write_wr_pulses got %0d want 2", wr_cnt - w0); end
    endtask

    task automatic test_read();
        read_burst(24'h000010, 4);
        vectors++; if (rq[0] !== 8'hA5) begin errors++; $display("FAIL read_b0 got %h want a5", rq[0]); end
        vectors++; if (rq[1] !== 8'h3C) begin errors++; $display("FAIL read_b1 got %h want 3c", rq[1]); end
        vectors++; if (rq[2] !== ref_mem[18]) begin errors++; $display("FAIL read_b2 got %h want %h", rq[2], ref_mem[18]); end
        vectors++; if (rq[3] !== ref_mem[19]) begin errors++; $display("FAIL read_b3 got %h want %h", rq[3], ref_mem[19]); end
    endtask

    task automatic test_wrap();
        int w0;
        w0 = wr_cnt;
        wq.push_back(8'h11);
        wq.push_back(8'h22);
        write_burst(24'h0123FF);
        vectors++; if (wr_cnt - w0 !== 2) begin errors++; $display("FAIL wrap_wr_pulses got %0d want 2", wr_cnt - w0); end
        read_burst(24'h0003FF, 2);
        vectors++; if (rq[0] !== 8'h11) begin errors++; $display("FAIL wrap_3ff got %h want 11", rq[0]); end
        vectors++; if (rq[1] !== 8'h22) begin errors++; $display("FAIL wrap_000 got %h want 22", rq[1]); end
    endtask

    task automatic test_abort();
        logic [7:0] r;
        int w0;
        w0 = wr_cnt;
        cs_begin();
        send_hdr(8'h02, 24'h000020);
        spi_xfer(~ref_mem[32], 5, r);
        cs_end();
        vectors++; if (wr_cnt - w0 !== 0) begin errors++; $display("FAIL abort_wr_pulses got %0d want 0", wr_cnt - w0); end
        read_burst(24'h000020, 1);
        vectors++; if (rq[0] !== ref_mem[32]) begin errors++; $display("FAIL abort_readback got %h want %h", rq[0], ref_mem[32]); end
    endtask

    task automatic test_bad_opcode();
        logic [7:0] r;
        int w0, m0;
        w0 = wr_cnt;
        m0 = miso_hi;
        cs_begin();
        spi_xfer(8'h9F, 8, r);
        for (int i = 0; i < 3; i++) spi_xfer(8'($urandom), 8, r);
        cs_end();
        vectors++; if (miso_hi - m0 !== 0) begin errors++; $display("FAIL badop_miso got %0d high samples want 0", miso_hi - m0); end
        vectors++; if (cmd_err !== 1'b1)   begin errors++; $display("FAIL badop_cmd_err got %b want 1", cmd_err); end
        vectors++; if (wr_cnt - w0 !== 0)  begin errors++; $display("FAIL badop_wr_pulses got %0d want 0", wr_cnt - w0); end
        read_burst(24'h000010, 2);
        vectors++; if (rq[0] !== ref_mem[16]) begin errors++; $display("FAIL badop_next_b0 got %h want %h", rq[0], ref_mem[16]); end
        vectors++; if (rq[1] !== ref_mem[17]) begin errors++; $display("FAIL badop_next_b1 got %h want %h", rq[1], ref_mem[17]); end
        vectors++; if (cmd_err !== 1'b1)      begin errors++; $display("FAIL badop_sticky got %b want 1", cmd_err); end
    endtask

    // Reset in the middle of a read byte (A5: third bit driven is a 1).
    task automatic test_reset_mid();
        logic [7:0] r;
        cs_begin();
        send_hdr(8'h03, 24'h000010);
        spi_xfer(8'h00, 2, r);
        wait_clk(HALF);
        vectors++; if (MISO !== ref_mem[16][5]) begin errors++; $display("FAIL rstmid_pre_miso got %b want %b", MISO, ref_mem[16][5]); end
        rst = 1'b1;
        #1;
        vectors++; if (MISO !== 1'b0) begin errors++; $display("FAIL rstmid_miso got %b want 0", MISO); end
        vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b want 0", busy); end
        vectors++; if (cmd_err !== 1'b0) begin errors++; $display("FAIL rstmid_cmd_err got %b want 0", cmd_err); end
        CS_N = 1'b1;
        MOSI = 1'b0;
        wait_clk(3);
        rst = 1'b0;
        wait_clk(4);
        read_burst(24'h000010, 1);
        vectors++; if (rq[0] !== 8'hA5) begin errors++; $display("FAIL rstmid_reread got %h want a5", rq[0]); end
    endtask

    // Random write bursts at random 24-bit addresses, read back with margin.
    task automatic test_random();
        logic [23:0] a;
        int len, w0, idx;
        for (int it = 0; it < 6; it++) begin
            a   = 24'($urandom);
            len = $urandom_range(1, 5);
            w0  = wr_cnt;
            for (int i = 0; i < len; i++) wq.push_back(8'($urandom));
            write_burst(a);
            vectors++;
            if (wr_cnt - w0 !== len) begin errors++; $display("FAIL rand_wr_pulses it=%0d got %0d want %0d", it, wr_cnt - w0, len); end
            read_burst(a, len + 1);
            for (int i = 0; i < len + 1; i++) begin
                idx = (int'(a) + i) % DEPTH;
                if (known[idx]) begin
                    vectors++;
                    if (rq[i] !== ref_mem[idx]) begin
                        errors++;
                        $display("FAIL rand_read it=%0d addr=%03h got %h want %h", it, idx, rq[i], ref_mem[idx]);
                    end
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            ref_mem[i] = 8'h00;
            known[i]   = 1'b0;
        end
        test_reset();
        test_prefill();
        test_write();
        test_read();
        test_wrap();
        test_abort();
        test_bad_opcode();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
